// File: rtl/acc_apb_sequencer.sv
// acc_apb_sequencer: APB master that runs one accelerator job:
// clock-gate on, A/X operand load, result readback, clock-gate off.
module acc_apb_sequencer #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CNT_W          = 10,
    parameter int RD_STEP        = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      start,
    input  logic [CNT_W-1:0]          a_cnt,
    input  logic [CNT_W-1:0]          x_cnt,
    input  logic [CNT_W-1:0]          r_cnt,
    input  logic [APB_ADDR_WIDTH-1:0] r_base,
    input  logic [31:0]               in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [31:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CG =
        APB_ADDR_WIDTH'(12'hFF0);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_A =
        APB_ADDR_WIDTH'(12'hFF4);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_X =
        APB_ADDR_WIDTH'(12'hFF8);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EN,
        S_LOAD_A,
        S_LOAD_X,
        S_READ,
        S_DIS,
        S_FIN
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t after_en;
    state_t after_a;
    state_t after_x;

    logic                      acc;
    logic                      setup;
    logic                      xfer_done;
    logic                      slot_free;
    logic [CNT_W-1:0]          a_rem;
    logic [CNT_W-1:0]          x_rem;
    logic [CNT_W-1:0]          r_rem;
    logic [APB_ADDR_WIDTH-1:0] raddr;
    logic [31:0]               wdata_q;

    assign xfer_done = acc & PREADY;
    assign slot_free = ~out_valid | out_ready;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);

    // Next phase after each stage, skipping stages with no words.
    always_comb begin
        after_x  = (r_rem != '0) ? S_READ : S_DIS;
        after_a  = (x_rem != '0) ? S_LOAD_X : after_x;
        after_en = (a_rem != '0) ? S_LOAD_A : after_a;
    end

    // State register; reset aborts a job in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: advance on completed transfers, bail to DIS on error.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_EN;
            end
            S_EN: begin
                if (xfer_done)
                    state_nxt = PSLVERR ? S_DIS : after_en;
            end
            S_LOAD_A: begin
                if (xfer_done) begin
                    if (PSLVERR)         state_nxt = S_DIS;
                    else if (a_rem == ONE) state_nxt = after_a;
                end
            end
            S_LOAD_X: begin
                if (xfer_done) begin
                    if (PSLVERR)         state_nxt = S_DIS;
                    else if (x_rem == ONE) state_nxt = after_x;
                end
            end
            S_READ: begin
                if (xfer_done) begin
                    if (PSLVERR || r_rem == ONE) state_nxt = S_DIS;
                end
            end
            S_DIS: begin
                if (xfer_done) state_nxt = S_FIN;
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // APB request: setup only when the word or result slot is ready.
    always_comb begin
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        PWRITE   = 1'b0;
        PADDR    = '0;
        PWDATA   = '0;
        in_ready = 1'b0;
        setup    = 1'b0;
        unique case (state)
            S_EN: begin
                setup   = ~acc;
                PSEL    = 1'b1;
                PENABLE = acc;
                PWRITE  = 1'b1;
                PADDR   = ADDR_CG;
                PWDATA  = 32'd1;
            end
            S_LOAD_A, S_LOAD_X: begin
                setup    = ~acc & in_valid;
                in_ready = setup;
                PSEL     = acc | in_valid;
                PENABLE  = acc;
                PWRITE   = 1'b1;
                PADDR    = (state == S_LOAD_A) ? ADDR_A : ADDR_X;
                PWDATA   = acc ? wdata_q : in_data;
            end
            S_READ: begin
                setup   = ~acc & slot_free;
                PSEL    = acc | slot_free;
                PENABLE = acc;
                PADDR   = raddr;
            end
            S_DIS: begin
                setup   = ~acc & slot_free;
                PSEL    = acc | slot_free;
                PENABLE = acc;
                PWRITE  = 1'b1;
                PADDR   = ADDR_CG;
            end
            default: begin
            end
        endcase
    end

    // Transfer phase, job counters, operand and result registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            acc       <= 1'b0;
            a_rem     <= '0;
            x_rem     <= '0;
            r_rem     <= '0;
            raddr     <= '0;
            wdata_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (setup) begin
                acc <= 1'b1;
            end else if (xfer_done) begin
                acc <= 1'b0;
            end
            if (state == S_IDLE && start) begin
                a_rem <= a_cnt;
                x_rem <= x_cnt;
                r_rem <= r_cnt;
                raddr <= r_base;
                err   <= 1'b0;
            end
            if (in_ready) begin
                wdata_q <= in_data;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer_done) begin
                if (PSLVERR) err <= 1'b1;
                case (state)
                    S_LOAD_A: a_rem <= a_rem - ONE;
                    S_LOAD_X: x_rem <= x_rem - ONE;
                    S_READ: begin
                        r_rem <= r_rem - ONE;
                        raddr <= raddr + APB_ADDR_WIDTH'(RD_STEP);
                        if (!PSLVERR) begin
                            out_data  <= PRDATA;
                            out_valid <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_apb_sequencer.sv
// tb_acc_apb_sequencer: randomized jobs against a transfer-list
// model of the sequencer, plus directed stall/error/reset cases.
module tb_acc_apb_sequencer;

    localparam int AW = 12;
    localparam int CW = 10;
    localparam logic [AW-1:0] A_CG = 12'hFF0;
    localparam logic [AW-1:0] A_A  = 12'hFF4;
    localparam logic [AW-1:0] A_X  = 12'hFF8;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } xfer_t;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] a_cnt = '0;
    logic [CW-1:0] x_cnt = '0;
    logic [CW-1:0] r_cnt = '0;
    logic [AW-1:0] r_base = '0;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [31:0]   PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    acc_apb_sequencer #(
        .APB_ADDR_WIDTH(AW),
        .CNT_W(CW),
        .RD_STEP(1)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .start(start),
        .a_cnt(a_cnt),
        .x_cnt(x_cnt),
        .r_cnt(r_cnt),
        .r_base(r_base),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .err(err),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PWRITE(PWRITE),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] src_q[$];
    xfer_t       obs_q[$];
    xfer_t       exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] res_q[$];

    int stall_after = -1;
    int stall_len = 0;
    int stall_left = 0;
    int rd_wait = 0;
    int wait_left = 0;
    int sink_hold = 0;
    int hold_left = 0;
    bit hold_arm = 1'b0;
    bit rand_src = 1'b0;
    bit rand_sink = 1'b0;
    bit rand_wait = 1'b0;
    int err_at = -1;
    int xfer_idx = 0;
    bit in_access = 1'b0;
    bit stalled = 1'b0;
    int cyc = 0;
    int done_cyc = -1;
    int done_cnt = 0;
    int inrdy_cnt = 0;
    int src_sent = 0;
    bit ov_seen = 1'b0;
    bit saw_x = 1'b0;
    xfer_t su;

    bit exp_err;
    int exp_ops;
    int exp_res;
    int exp_done;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      tag, got, exp);
    endtask

    function automatic xfer_t mk(input logic w, input logic [AW-1:0] a,
                                 input logic [31:0] d);
        xfer_t t;
        t.w = w;
        t.a = a;
        t.d = d;
        return t;
    endfunction

    // One clock: drive source/sink/slave at negedge, sample 1ns later.
    task automatic tick(input bit st);
        xfer_t cur;
        @(negedge HCLK);
        start = st;
        stalled = 1'b0;
        if (stall_left > 0) begin
            in_valid = 1'b0;
            stall_left--;
            stalled = 1'b1;
        end else begin
            in_valid = (src_q.size() > 0) &&
                       (!rand_src || $urandom_range(0, 3) != 0);
        end
        if (in_valid) in_data = src_q[0];
        else in_data = $urandom;
        if (hold_arm && out_valid) begin
            hold_left = sink_hold;
            hold_arm = 1'b0;
        end
        if (hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end else begin
            out_ready = !rand_sink || $urandom_range(0, 2) != 0;
        end
        PSLVERR = 1'b0;
        if (PSEL && PENABLE) begin
            if (!in_access) begin
                in_access = 1'b1;
                if (rand_wait) wait_left = $urandom_range(0, 2);
                else wait_left = PWRITE ? 0 : rd_wait;
            end
            if (wait_left > 0) begin
                PREADY = 1'b0;
                wait_left--;
            end else begin
                PREADY = 1'b1;
                PRDATA = $urandom;
                PSLVERR = (xfer_idx == err_at);
            end
        end else begin
            PREADY = $urandom_range(0, 1) != 0;
            PRDATA = $urandom;
            PSLVERR = $urandom_range(0, 1) != 0;
        end
        #1;
        if (!HRESETn) begin
            in_access = 1'b0;
            return;
        end
        if (start && !busy) cyc = 0;
        else cyc++;
        cur = mk(PWRITE, PADDR, PWRITE ? PWDATA : 32'd0);
        if (PSEL && !PENABLE) begin
            su = cur;
            if (PWRITE && PADDR != A_CG)
                check("setup_in_ready", in_ready, 1);
            if (!PWRITE || PADDR == A_CG)
                check("setup_sink_slot", out_valid && !out_ready, 0);
            if (PWRITE && PADDR == A_X) saw_x = 1'b1;
        end
        if (stalled && !PENABLE) check("psel_in_stall", PSEL, 0);
        if (PSEL && PENABLE) begin
            check("access_stable", cur, su);
            if (PREADY) begin
                obs_q.push_back(cur);
                if (!PWRITE && !PSLVERR) rd_q.push_back(PRDATA);
                xfer_idx++;
                in_access = 1'b0;
            end
        end
        if (in_ready) begin
            check("in_ready_valid", in_valid, 1);
            if (src_q.size() > 0) void'(src_q.pop_front());
            src_sent++;
            inrdy_cnt++;
            if (src_sent == stall_after) stall_left = stall_len;
        end
        if (out_valid) ov_seen = 1'b1;
        if (out_valid && out_ready) res_q.push_back(out_data);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Build the expected transfer list and pulse start.
    task automatic start_job(input int a, input int x, input int r,
                             input logic [AW-1:0] base, input int e_at);
        xfer_t full[$];
        logic [31:0] w;
        src_q.delete();
        obs_q.delete();
        exp_q.delete();
        rd_q.delete();
        res_q.delete();
        full.push_back(mk(1'b1, A_CG, 32'd1));
        for (int i = 0; i < a + x; i++) begin
            w = $urandom;
            src_q.push_back(w);
            full.push_back(mk(1'b1, (i < a) ? A_A : A_X, w));
        end
        for (int i = 0; i < r; i++)
            full.push_back(mk(1'b0, base + AW'(i), 32'd0));
        full.push_back(mk(1'b1, A_CG, 32'd0));
        exp_res = 0;
        if (e_at >= 0 && e_at < full.size() - 1) begin
            for (int i = 0; i <= e_at; i++) exp_q.push_back(full[i]);
            exp_q.push_back(full[full.size() - 1]);
            exp_err = 1'b1;
            if (!full[e_at].w) exp_res = -1;
        end else begin
            exp_q = full;
            exp_err = (e_at == full.size() - 1);
        end
        exp_ops = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i].w && exp_q[i].a != A_CG) exp_ops++;
            if (!exp_q[i].w) exp_res++;
        end
        exp_done = 2 * (2 + a + x + r) + 1;
        err_at = e_at;
        xfer_idx = 0;
        done_cnt = 0;
        done_cyc = -1;
        inrdy_cnt = 0;
        src_sent = 0;
        ov_seen = 1'b0;
        saw_x = 1'b0;
        stall_left = 0;
        hold_left = 0;
        hold_arm = (sink_hold > 0);
        a_cnt = CW'(a);
        x_cnt = CW'(x);
        r_cnt = CW'(r);
        r_base = base;
        tick(1'b1);
        tick(1'b0);
        check("err_clear", err, 0);
        check("busy_rise", busy, 1);
    endtask

    // Wait for done (bounded) and compare against the model.
    task automatic finish_job(input string nm, input bit best);
        int t = 0;
        while (done_cnt == 0 && t < 3000) begin
            tick(1'b0);
            t++;
        end
        repeat (3) tick(1'b0);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_busy_low"}, busy, 0);
        check({nm, "_err"}, err, exp_err);
        check({nm, "_ov_idle"}, out_valid, 0);
        check({nm, "_ops"}, inrdy_cnt, exp_ops);
        check({nm, "_nxfer"}, obs_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < obs_q.size())
                check({nm, "_xfer"}, obs_q[i], exp_q[i]);
        check({nm, "_nread"}, rd_q.size(), exp_res);
        check({nm, "_nres"}, res_q.size(), rd_q.size());
        foreach (rd_q[i])
            if (i < res_q.size())
                check({nm, "_res"}, res_q[i], rd_q[i]);
        if (best) check({nm, "_done_cyc"}, done_cyc, exp_done);
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "_psel"}, PSEL, 0);
        check({nm, "_penable"}, PENABLE, 0);
        check({nm, "_pwrite"}, PWRITE, 0);
        check({nm, "_paddr"}, PADDR, 0);
        check({nm, "_pwdata"}, PWDATA, 0);
        check({nm, "_in_ready"}, in_ready, 0);
        check({nm, "_out_valid"}, out_valid, 0);
        check({nm, "_out_data"}, out_data, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_err"}, err, 0);
    endtask

    initial begin
        int t;
        int a;
        int x;
        int r;
        int e;
        repeat (3) tick(1'b0);
        check_reset_outs("rst");
        HRESETn = 1'b1;
        repeat (2) tick(1'b0);

        start_job(3, 3, 2, 12'h010, -1);
        finish_job("basic", 1'b1);

        start_job(1, 2, 4, 12'hFFE, -1);
        finish_job("wrap", 1'b1);

        stall_after = 1;
        stall_len = 4;
        start_job(3, 3, 2, 12'h020, -1);
        finish_job("stall", 1'b0);
        stall_after = -1;

        rd_wait = 3;
        sink_hold = 5;
        start_job(2, 2, 3, 12'h100, -1);
        finish_job("wait", 1'b0);
        rd_wait = 0;
        sink_hold = 0;

        start_job(3, 3, 2, 12'h010, 2);
        finish_job("slverr", 1'b0);
        start_job(1, 1, 1, 12'h040, -1);
        finish_job("after_err", 1'b1);

        start_job(2, 4, 1, 12'h050, -1);
        t = 0;
        while (!saw_x && t < 200) begin
            tick(1'b0);
            t++;
        end
        check("rst_saw_load_x", saw_x, 1);
        #1 HRESETn = 1'b0;
        #1 check_reset_outs("async_rst");
        repeat (2) tick(1'b0);
        HRESETn = 1'b1;
        tick(1'b0);
        check("rst_idle", busy, 0);
        start_job(2, 1, 2, 12'h060, -1);
        finish_job("post_rst", 1'b1);

        start_job(0, 0, 0, 12'h000, -1);
        a_cnt = 3;
        r_cnt = 3;
        tick(1'b1);
        tick(1'b0);
        a_cnt = 0;
        r_cnt = 0;
        finish_job("zero", 1'b1);
        check("zero_no_in_ready", inrdy_cnt, 0);
        check("zero_no_out_valid", ov_seen, 0);

        rand_src = 1'b1;
        rand_sink = 1'b1;
        rand_wait = 1'b1;
        for (int k = 0; k < 12; k++) begin
            a = $urandom_range(0, 5);
            x = $urandom_range(0, 5);
            r = $urandom_range(0, 5);
            e = ($urandom_range(0, 3) == 0) ?
                $urandom_range(0, 2 + a + x + r) : -1;
            start_job(a, x, r, AW'($urandom), e);
            finish_job("rand", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/acc_apb_sequencer.md
# acc_apb_sequencer

APB master that drives one complete job through the matrix accelerator APB slave without CPU involvement per word. On `start` it enables the accelerator clock gate, streams A then X operand words from a valid/ready source into the load registers, reads back result words from the accelerator result RAM into a valid/ready sink, and finally disables the clock gate. It sits between a DMA/stream source and the accelerator's APB port, in place of CPU-driven APB writes.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width.
- `CNT_W`, 10, width of the per-job word counters.
- `RD_STEP`, 1, address increment between consecutive result reads.
- `HCLK`  in  1  clock; all logic is rising-edge.
- `HRESETn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle job request; ignored while `busy`.
- `a_cnt`, `x_cnt`, `r_cnt`  in  CNT_W  A words, X words and result words; latched on accepted `start`.
- `r_base`  in  APB_ADDR_WIDTH  address of the first result word; latched on `start`.
- `in_data`  in  32  operand word.
- `in_valid`  in  1  operand word available.
- `in_ready`  out  1  operand word consumed this cycle.
- `out_data`  out  32  result word.
- `out_valid`  out  1  result word held.
- `out_ready`  in  1  sink accepts result.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky; set by PSLVERR, cleared on next accepted `start`.
- `PADDR`  out  APB_ADDR_WIDTH; `PWDATA`  out  32; `PWRITE`, `PSEL`, `PENABLE`  out  1  APB master request.
- `PRDATA`  in  32; `PREADY`, `PSLVERR`  in  1  APB slave response.

## Operation
- States: IDLE, EN, LOAD_A, LOAD_X, READ, DIS, FIN.
- IDLE: `start` latches counts/base, clears `err`, goes to EN.
- EN: one write, PADDR=0xFF0, PWDATA=1. Then LOAD_A.
- LOAD_A: `a_cnt` writes to 0xFF4, data from `in_data`. Then LOAD_X.
- LOAD_X: `x_cnt` writes to 0xFF8, data from `in_data`. Then READ.
- READ: `r_cnt` reads, address `r_base + i*RD_STEP` (i from 0), modulo 2^APB_ADDR_WIDTH. Then DIS.
- DIS: one write, PADDR=0xFF0, PWDATA=0. Then FIN.
- FIN: `done`=1 for one cycle, `busy` drops, back to IDLE.
- Zero count skips that state (a_cnt=x_cnt=r_cnt=0 gives only the EN and DIS writes).
- Operand write issued only when `in_valid`=1. `in_ready`=1 in the setup cycle that captures `in_data` into PWDATA; never otherwise.
- Result read issued only when `out_valid`=0 (single-entry output register). PRDATA captured on the completing access cycle; `out_valid` holds until `out_ready`.
- PSLVERR=1 on any completing transfer in EN/LOAD_A/LOAD_X/READ: `err` set; the errored read's data is discarded; the FSM goes directly to DIS, then FIN. PSLVERR on the DIS write sets `err` only.
- A pending `out_valid` word must be accepted by the sink before DIS is issued.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `err`=0, state IDLE. Counters are cleared.
- Reset asserted mid-job aborts immediately. No DIS write is issued.
- APB setup cycle: PSEL=1, PENABLE=0. Access cycle(s): PSEL=1, PENABLE=1, held with stable PADDR/PWDATA/PWRITE until PREADY=1.
- The next setup may start in the cycle after completion. The minimum transfer is 2 cycles, with no idle cycles when data and sink are ready.
- `busy` rises the cycle after `start`; first setup (EN) is in that same cycle.
- `done` pulses the cycle after the DIS access completes.
- Best-case job length: 2·(2+a+x+r)+1 cycles from `start` to `done`.
- When the source/sink stalls, PSEL=0 between transfers. A transfer is never started and then withdrawn.

## Test plan
- a=3, x=3, r=2, r_base=0x010, PREADY=1, source and sink always ready. Bus sequence must be: W FF0=1; W FF4×3; W FF8×3 in order; R 0x010, R 0x011; W FF0=0. Expect `done` at cycle 21 after `start` and two `out_valid` words equal to the PRDATA values returned.
- Source stalls: `in_valid` low for 4 cycles before the second A word. PSEL must stay 0 for those cycles, with no duplicated or dropped word. `in_ready` must pulse exactly 6 times.
- Slave returns PREADY=0 for 3 access cycles on each read, and `out_ready` is held low for 5 cycles after the first result. Signals must stay stable during wait states. The second read setup must not occur until the first result is accepted.
- PSLVERR=1 on the second FF4 write. Expect `err`=1, no FF8 writes and no reads, then W FF0=0 and `done`. The next `start` must clear `err`.
- Assert HRESETn low during LOAD_X. All outputs must go to their reset values asynchronously and the FSM must return to IDLE. A subsequent job must run correctly.
- a=x=r=0. Expect only W FF0=1 and W FF0=0, `done` at cycle 5, and `in_ready`/`out_valid` never asserted. A `start` pulsed while `busy` must be ignored.
